// File: rtl/mux_pkg.sv
// Shared constants, types and helpers for the stream multiplexer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mux_pkg;

    localparam logic MODE_SEL = 1'b0;
    localparam logic MODE_RR  = 1'b1;

    localparam int DEF_WIDTH  = 16;
    localparam int DEF_NUM_CH = 8;

    typedef enum logic {
        ARB_IDLE,
        ARB_LOCKED
    } arb_state_t;

    // Smallest r with 2**r >= v.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first requester strictly after ptr, wrapping modulo NUM_CH.
// Latency: purely combinational.
// Backpressure: none; the caller qualifies the grant.
module rr_arbiter #(
    parameter int NUM_CH = 8,
    parameter int SEL_W  = 4
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic [SEL_W-1:0]  grant,
    output logic              grant_valid
);

    logic [NUM_CH-1:0] rot;
    int                start;
    int                off;
    int                idx;

    always_comb begin
        start = (int'(ptr) >= NUM_CH - 1) ? 0 : int'(ptr) + 1;
        // Doubling the request vector turns the rotate into a plain shift.
        rot   = NUM_CH'({req, req} >> start);
        grant_valid = |rot;
        off = 0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (rot[i]) off = i;
        end
        idx = start + off;
        if (idx >= NUM_CH) idx = idx - NUM_CH;
        grant = SEL_W'(idx);
    end

endmodule

// File: rtl/stream_mux_arb.sv
// N-channel packet-aware stream mux, explicit-select or round-robin, registered output.
// Latency: 1 cycle from input transfer to out_valid; 1 beat/cycle throughput.
// Backpressure: out_ready=0 with a held beat freezes the output and drops all in_ready.
import mux_pkg::*;

module stream_mux_arb #(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int SEL_W  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    input  logic [NUM_CH-1:0]       in_valid,
    input  logic [NUM_CH-1:0]       in_last,
    output logic [NUM_CH-1:0]       in_ready,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    output logic                    out_last,
    output logic [SEL_W-1:0]        out_chan,
    input  logic                    out_ready
);

    if (SEL_W < clog2(NUM_CH) || NUM_CH < 2 || NUM_CH > 16) begin : g_param_chk
        $error("stream_mux_arb: NUM_CH must be 2..16 and fit in SEL_W bits");
    end

    localparam logic [SEL_W:0] NUM_CH_L = (SEL_W + 1)'(NUM_CH);

    arb_state_t        state;
    arb_state_t        state_nxt;
    logic [SEL_W-1:0]  lock_ch;
    logic [SEL_W-1:0]  rr_ptr;

    logic [SEL_W-1:0]  rr_gnt;
    logic              rr_vld;
    logic [SEL_W-1:0]  gnt;
    logic              gnt_vld;
    logic [WIDTH-1:0]  g_dat;
    logic              g_last;
    logic              g_valid;
    logic              load;
    logic              xfer;

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .SEL_W  (SEL_W)
    ) u_rr_arbiter (
        .req         (in_valid),
        .ptr         (rr_ptr),
        .grant       (rr_gnt),
        .grant_valid (rr_vld)
    );

    assign load = ~out_valid | out_ready;

    // A locked packet owns the output regardless of mode/sel changes.
    always_comb begin
        gnt     = '0;
        gnt_vld = 1'b0;
        if (state == ARB_LOCKED) begin
            gnt     = lock_ch;
            gnt_vld = 1'b1;
        end else if (mode == MODE_SEL) begin
            gnt     = sel;
            gnt_vld = ({1'b0, sel} < NUM_CH_L);
        end else begin
            gnt     = rr_gnt;
            gnt_vld = rr_vld;
        end
    end

    always_comb begin
        g_dat    = '0;
        g_last   = 1'b0;
        g_valid  = 1'b0;
        in_ready = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (gnt == SEL_W'(i)) begin
                g_dat       = in_data[i*WIDTH +: WIDTH];
                g_last      = in_last[i];
                g_valid     = in_valid[i];
                in_ready[i] = ~rst & load & gnt_vld;
            end
        end
        xfer = ~rst & load & gnt_vld & g_valid;
    end

    always_comb begin
        state_nxt = state;
        if (xfer) begin
            state_nxt = g_last ? ARB_IDLE : ARB_LOCKED;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ARB_IDLE;
            lock_ch   <= '0;
            rr_ptr    <= SEL_W'(NUM_CH - 1);
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_chan  <= '0;
        end else begin
            state <= state_nxt;
            if (load) begin
                out_valid <= xfer;
            end
            if (xfer) begin
                out_data <= g_dat;
                out_last <= g_last;
                out_chan <= gnt;
                rr_ptr   <= gnt;
                lock_ch  <= gnt;
            end
        end
    end

endmodule

// File: tb/tb_stream_mux_arb.sv
// Randomized scoreboard bench for stream_mux_arb against a queue-based reference model.
// Latency: model predicts in_ready per cycle and the output beat one cycle after transfer.
// Backpressure: random out_ready; stalled output beats must hold steady.
module tb_stream_mux_arb;

    localparam int W  = 16;
    localparam int N  = 8;
    localparam int SW = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N*W-1:0]  in_data = '0;
    logic [N-1:0]    in_valid = '0;
    logic [N-1:0]    in_last = '0;
    logic [N-1:0]    in_ready;
    logic            mode = 1'b0;
    logic [SW-1:0]   sel = '0;
    logic [W-1:0]    out_data;
    logic            out_valid;
    logic            out_last;
    logic [SW-1:0]   out_chan;
    logic            out_ready = 1'b0;

    stream_mux_arb #(.WIDTH(W), .NUM_CH(N), .SEL_W(SW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_chan  (out_chan),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    // Per-channel source queues: {last, data}.
    logic [W:0]      src_q [N][$];
    // Scoreboard of expected output beats: {data, last, chan}.
    logic [W+SW:0]   sb [$];

    int compared   = 0;
    int mismatched = 0;

    int valid_pct = 100;
    int ready_pct = 100;
    logic          nx_rst  = 1'b1;
    logic          nx_mode = 1'b0;
    logic [SW-1:0] nx_sel  = '0;

    // Reference model state: output register occupancy, locked channel (-1 none), last winner.
    bit m_ov     = 1'b0;
    int m_lock   = -1;
    int m_ptr    = N - 1;
    bit m_load   = 1'b0;
    bit exp_xfer = 1'b0;
    int exp_g    = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_grant();
        if (m_lock >= 0) return m_lock;
        if (mode == 1'b0) return (int'(sel) < N) ? int'(sel) : -1;
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (m_ptr + k) % N;
            if (in_valid[c]) return c;
        end
        return -1;
    endfunction

    task automatic add_pkt(input int ch, input int len, input logic [W-1:0] base);
        for (int k = 0; k < len; k++) begin
            src_q[ch].push_back({(k == len - 1) ? 1'b1 : 1'b0, base + W'(k)});
        end
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < N; i++) begin
            if (src_q[i].size() != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic cycle();
        logic [W:0]     b;
        logic [N-1:0]   exp_rdy;
        int             g;
        @(posedge clk);
        if (rst) begin
            m_ov   = 1'b0;
            m_lock = -1;
            m_ptr  = N - 1;
            sb.delete();
        end else begin
            if (m_load) m_ov = exp_xfer;
            if (exp_xfer) begin
                b = src_q[exp_g].pop_front();
                sb.push_back({b[W-1:0], b[W], SW'(exp_g)});
                m_ptr  = exp_g;
                m_lock = b[W] ? -1 : exp_g;
            end
        end
        #2;
        rst  = nx_rst;
        mode = nx_mode;
        sel  = nx_sel;
        for (int i = 0; i < N; i++) begin
            if (src_q[i].size() > 0 && int'($urandom_range(99)) < valid_pct) begin
                in_valid[i]         = 1'b1;
                in_data[i*W +: W]   = src_q[i][0][W-1:0];
                in_last[i]          = src_q[i][0][W];
            end else begin
                in_valid[i]         = 1'b0;
                in_data[i*W +: W]   = '0;
                in_last[i]          = 1'b0;
            end
        end
        out_ready = (int'($urandom_range(99)) < ready_pct);
        #2;
        g        = model_grant();
        m_load   = !m_ov || out_ready;
        exp_g    = g;
        exp_xfer = !rst && m_load && g >= 0 && in_valid[g];
        exp_rdy  = '0;
        if (!rst && m_load && g >= 0) exp_rdy[g] = 1'b1;
        check("in_ready", 32'(in_ready), 32'(exp_rdy));
        check("out_valid", 32'(out_valid), 32'(m_ov));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // Monitor: consumes beats as the downstream accepts them, and checks stall stability.
    bit            stall_prev = 1'b0;
    logic [W+SW+1:0] held;
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("stall_hold", 32'({out_valid, out_data, out_last, out_chan}), 32'(held));
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL beat: unexpected beat chan %0d data 0x%0h, expected none",
                             out_chan, out_data);
                end else begin
                    check("beat", 32'({out_data, out_last, out_chan}), 32'(sb.pop_front()));
                end
            end
            stall_prev = out_valid && !out_ready;
            held       = {out_valid, out_data, out_last, out_chan};
        end
    end

    task automatic drain();
        int budget;
        budget    = 0;
        nx_mode   = 1'b1;
        valid_pct = 100;
        ready_pct = 100;
        while ((!all_empty() || m_ov) && budget < 3000) begin
            cycle();
            budget++;
        end
        if (budget >= 3000) check("drain_timeout", 32'(budget), 32'(0));
    endtask

    initial begin
        // Reset with a pending source beat: nothing may be accepted.
        add_pkt(3, 1, 16'h1111);
        nx_rst = 1'b1;
        run(3);
        check("rst_out_data", 32'(out_data), 32'(0));
        check("rst_out_last", 32'(out_last), 32'(0));
        check("rst_out_chan", 32'(out_chan), 32'(0));

        // Explicit select of channel 3, single-beat packet.
        nx_rst  = 1'b0;
        nx_mode = 1'b0;
        nx_sel  = 4'd3;
        run(4);

        // Round-robin over all channels continuously valid, single-beat packets.
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < N; i++) add_pkt(i, 1, W'(16'h00A0 + i));
        end
        nx_mode = 1'b1;
        run(20);

        // Packet lock: ch2 4-beat packet holds the grant while ch5 waits.
        add_pkt(2, 4, 16'h0200);
        add_pkt(5, 1, 16'h0500);
        run(10);

        // Select changes mid-packet are deferred until after the last beat.
        add_pkt(1, 4, 16'h0100);
        add_pkt(6, 2, 16'h0600);
        nx_mode = 1'b0;
        nx_sel  = 4'd1;
        run(2);
        nx_sel = 4'd6;
        run(10);

        // Output stall for several cycles, then release.
        add_pkt(0, 3, 16'h0C00);
        nx_mode   = 1'b1;
        ready_pct = 0;
        run(7);
        ready_pct = 100;
        run(6);

        // Out-of-range select with every channel valid.
        for (int i = 0; i < N; i++) add_pkt(i, 1, W'(16'h0900 + i));
        nx_mode = 1'b0;
        nx_sel  = 4'd9;
        run(5);
        drain();

        // Reset mid-packet drops the held beat and clears the lock.
        add_pkt(4, 5, 16'h0400);
        nx_mode = 1'b1;
        run(3);
        nx_rst = 1'b1;
        run(1);
        nx_rst = 1'b0;
        add_pkt(0, 1, 16'h0D00);
        nx_mode = 1'b0;
        nx_sel  = 4'd0;
        run(4);
        drain();

        // Randomized traffic, modes, selects and backpressure.
        valid_pct = 75;
        ready_pct = 70;
        for (int c = 0; c < 1500; c++) begin
            int ch;
            ch = int'($urandom_range(N - 1));
            if (src_q[ch].size() < 4) add_pkt(ch, int'($urandom_range(4, 1)), W'($urandom));
            if ($urandom_range(99) < 5)  nx_mode = ~nx_mode;
            if ($urandom_range(99) < 10) nx_sel  = SW'($urandom_range(15));
            cycle();
        end
        drain();
        run(3);
        check("sb_empty", 32'(sb.size()), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
